// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline constants for the hazard stall controller.
package hazard_stall_ctrl_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [0:0] state_t;
    localparam state_t RUN      = 1'b0;
    localparam state_t MDU_WAIT = 1'b1;

    localparam int unsigned MDU_LAT_DEFAULT = 4;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter, used for the optional hazard statistics.
module hazard_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / MDU-occupancy / branch-flush controller for the 5-stage pipeline.
// Define HAZARD_STALL_PERF_EN to add stall and flush event counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [4:0] if_id_rs_i,
    input  logic [4:0] if_id_rt_i,
    input  logic       if_id_uses_rt_i,
    input  logic [4:0] id_ex_rt_i,
    input  logic       id_ex_memread_i,
    input  logic       id_ex_mdu_i,
    input  logic       branch_taken_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       if_id_flush_o,
    output logic       id_ex_write_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_flush_o,
    output logic       mdu_busy_o
`ifdef HAZARD_STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_events_o
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    assign load_use = id_ex_memread_i && (id_ex_rt_i != REG_ZERO) &&
                      ((id_ex_rt_i == if_id_rs_i) ||
                       (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mdu_busy_o     = (state_q == MDU_WAIT);

        if (!rst_n) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mdu_busy_o     = 1'b0;
        end else if (branch_taken_i) begin
            // Any MDU op in EX is younger than the branch and is squashed.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            state_d        = RUN;
            cnt_d          = '0;
        end else if (state_q == RUN) begin
            if (id_ex_mdu_i && (MDU_LAT >= 2)) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_write_o  = 1'b0;
                ex_mem_flush_o = 1'b1;
                state_d        = MDU_WAIT;
                cnt_d          = CNT_W'(MDU_LAT - 1);
            end else if (load_use) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_flush_o  = 1'b1;
            end
        end else begin
            if (cnt_q > CNT_W'(1)) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_write_o  = 1'b0;
                ex_mem_flush_o = 1'b1;
                cnt_d          = cnt_q - CNT_W'(1);
            end else begin
                // Release: EX/MEM captures the MDU result this cycle.
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    hazard_perf_cnt #(
        .W(32)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .inc_i  (~pc_write_o),
        .count_o(stall_cycles_o)
    );

    hazard_perf_cnt #(
        .W(16)
    ) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .inc_i  (branch_taken_i),
        .count_o(flush_events_o)
    );
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; the counterpart to the EX-stage forwarding unit.
- Forwarding resolves what can be bypassed. This block handles the cases bypassing cannot: load-use, multi-cycle MDU ops occupying EX, and taken-branch flush.
- Drives write-enables of PC, IF/ID and ID/EX, and flushes of IF/ID, ID/EX and EX/MEM.
- Mealy FSM (RUN, MDU_WAIT) with a down-counter for MDU occupancy.

Parameters:
- MDU_LAT, 4, total cycles a mul/div must occupy EX (legal 1..15; 1 = no MDU stall).
- CNT_W, 4, width of the MDU occupancy counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_id_rs_i  in  5  rs of instruction in ID
- if_id_rt_i  in  5  rt of instruction in ID
- if_id_uses_rt_i  in  1  ID instruction reads rt as a source
- id_ex_rt_i  in  5  destination rt of instruction in EX
- id_ex_memread_i  in  1  EX instruction is a load
- id_ex_mdu_i  in  1  EX instruction is mul/div
- branch_taken_i  in  1  branch in MEM resolved taken
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID clear to NOP
- id_ex_write_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX control clear (bubble)
- ex_mem_flush_o  out  1  EX/MEM control clear (bubble)
- mdu_busy_o  out  1  FSM in MDU_WAIT

Behaviour:
- Reset: async on rst_n=0 → state RUN, cnt=0.
- While rst_n=0: pc_write_o, if_id_write_o and id_ex_write_o are 0; all three flushes are 1; mdu_busy_o=0.
- Default (RUN, no hazard): all write enables 1, all flushes 0.
- Hazard definitions:
  - load_use = id_ex_memread_i & (id_ex_rt_i!=0) & ((id_ex_rt_i==if_id_rs_i) | (if_id_uses_rt_i & id_ex_rt_i==if_id_rt_i)).
  - Register 0 never causes a hazard.
- Priority within a cycle: branch_taken_i > MDU > load_use.
- Branch taken (any state):
  - if_id_flush_o=1, id_ex_flush_o=1, ex_mem_flush_o=1; pc_write_o=1; if_id_write_o=1.
  - Next state RUN, cnt cleared. An MDU op in EX is younger, so it is squashed (abort).
- RUN & id_ex_mdu_i & MDU_LAT>=2:
  - Outputs: pc_write_o=0, if_id_write_o=0, id_ex_write_o=0, ex_mem_flush_o=1.
  - Next state MDU_WAIT, cnt←MDU_LAT-1.
- RUN & load_use (no MDU):
  - pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1. Single-cycle bubble, state stays RUN.
  - Next cycle the load is in MEM; forwarding covers it.
- MDU_WAIT, cnt>1:
  - Same freeze outputs as MDU entry; cnt decrements. id_ex_mdu_i and load_use are ignored.
  - mdu_busy_o=1; id_ex_flush_o=0 (EX contents held).
- MDU_WAIT, cnt==1:
  - Release: all write enables 1, ex_mem_flush_o=0 so the MDU result latches into EX/MEM.
  - Next state RUN, cnt←0. mdu_busy_o=1 this cycle.
- Total EX occupancy of an MDU op = MDU_LAT cycles, so stall cycles seen by the front end = MDU_LAT-1.
- Back-to-back MDU ops: the second reaches EX the cycle after release, is seen in RUN, and re-enters MDU_WAIT.
- MDU_LAT==1: id_ex_mdu_i is ignored, FSM never leaves RUN.
- Counter never wraps; loaded only in RUN.

Optional Feature:
- Macro HAZARD_STALL_PERF_EN.
- When defined, adds:
  - output stall_cycles_o [31:0]: saturating count of cycles with pc_write_o=0 while rst_n=1.
  - output flush_events_o [15:0]: saturating count of cycles with branch_taken_i=1.
  - Both reset to 0 asynchronously and hold at all-ones.
- When undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (pipeline constants/types):
  - REG_ZERO = 5'd0.
  - state enum {RUN, MDU_WAIT}.
  - MDU_LAT default constant.
- One natural sub-module, hazard_perf_cnt (saturating counters), instantiated only under HAZARD_STALL_PERF_EN.
- Hazard compare logic stays inline.

Test Plan:
- Load-use: lw writes $8 in EX, add $9,$8,$10 in ID (rs=8) → one cycle with pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next cycle all enables 1.
- Load targets $0: id_ex_rt_i=0, if_id_rs_i=0, memread=1 → no stall, all write enables 1.
- rt not a source: id_ex_rt_i=5, if_id_rt_i=5, if_id_uses_rt_i=0 → no stall.
- MDU, MDU_LAT=4: id_ex_mdu_i=1 at T → freeze at T, T+1, T+2 (mdu_busy_o=1 from T+1); release at T+3 with ex_mem_flush_o=0; RUN at T+4.
- Branch abort: branch_taken_i=1 at T+1 during MDU_WAIT → all flushes 1, pc_write_o=1, state RUN at T+2, mdu_busy_o=0.
- Async reset mid-MDU: rst_n low between edges at T+1 → outputs go to reset values immediately (no clock edge); after release, RUN with cnt=0 and no residual stall.
